// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encodings
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with valid/ack handshake and error flags
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

    uart_state_t                 state;
    logic [CW-1:0]               cnt;
    logic [2:0]                  bit_cnt;
    logic [UART_DATA_BITS-1:0]   shift;
    logic                        rxd_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_ack && rx_valid)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rxd_s == START_BIT) begin
                        bit_cnt <= '0;
                        if (HALF == 0) begin
                            state <= DATA;
                            cnt   <= '0;
                        end else begin
                            state <= START;
                            cnt   <= CW'(1);
                        end
                    end
                end
                START: begin
                    if (cnt != CNT_HALF) begin
                        cnt <= cnt + CW'(1);
                    end else if (rxd_s != START_BIT) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift   <= {rxd_s, shift[UART_DATA_BITS-1:1]};
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxd_s == STOP_BIT) begin
                            // Later assignment wins over the ack clear: a byte landing with ack stays valid.
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_ack)
                                overrun <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            shift     <= '0;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rxd_s == STOP_BIT)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver at 1 and 4 clocks per bit
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd1 = 1'b1, rxd4 = 1'b1;
    logic       ack1 = 1'b0, ack4 = 1'b0;
    logic [7:0] data1, data4;
    logic       v1, v4, fe1, fe4, ov1, ov4;

    int total = 0;
    int bad   = 0;
    int fe1_n = 0, fe4_n = 0, ov1_n = 0, ov4_n = 0;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd1), .rx_ack(ack1),
        .rx_data(data1), .rx_valid(v1), .frame_err(fe1), .overrun(ov1)
    );

    uart_receiver #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .rxd(rxd4), .rx_ack(ack4),
        .rx_data(data4), .rx_valid(v4), .frame_err(fe4), .overrun(ov4)
    );

    always @(negedge clk) begin
        if (fe1) fe1_n++;
        if (fe4) fe4_n++;
        if (ov1) ov1_n++;
        if (ov4) ov4_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        fe1_n = 0; fe4_n = 0; ov1_n = 0; ov4_n = 0;
    endtask

    task automatic set_line(input int cpb, input logic b);
        if (cpb == 1) rxd1 = b;
        else          rxd4 = b;
    endtask

    task automatic set_ack(input int cpb, input logic a);
        if (cpb == 1) ack1 = a;
        else          ack4 = a;
    endtask

    // Leaves the line at the stop-bit level when done.
    task automatic send_frame(input int cpb, input logic [7:0] b, input logic stop);
        set_line(cpb, 1'b0);
        repeat (cpb) tick();
        for (int i = 0; i < 8; i++) begin
            set_line(cpb, b[i]);
            repeat (cpb) tick();
        end
        set_line(cpb, stop);
        repeat (cpb) tick();
    endtask

    task automatic wait_valid(input int cpb, input int limit, output int n);
        n = 0;
        while (!((cpb == 1) ? v1 : v4) && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        total++;
        if ({data1, v1, fe1, ov1} !== 11'd0) begin
            bad++;
            $display("FAIL reset_dut1 got data=%h v=%b fe=%b ov=%b want all 0", data1, v1, fe1, ov1);
        end
        total++;
        if ({data4, v4, fe4, ov4} !== 11'd0) begin
            bad++;
            $display("FAIL reset_dut4 got data=%h v=%b fe=%b ov=%b want all 0", data4, v4, fe4, ov4);
        end
        rst = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_latency();
        int n;
        clear_flags();
        send_frame(1, 8'hA5, 1'b1);
        wait_valid(1, 20, n);
        total++;
        if (10 + n != 12) begin
            bad++;
            $display("FAIL latency_a5 got %0d cycles want 12", 10 + n);
        end
        total++;
        if (data1 !== 8'hA5) begin
            bad++;
            $display("FAIL data_a5 got %h want a5", data1);
        end
        total++;
        if (fe1_n != 0 || ov1_n != 0) begin
            bad++;
            $display("FAIL flags_a5 got fe=%0d ov=%0d want 0 0", fe1_n, ov1_n);
        end
        ack1 = 1'b1; tick(); ack1 = 1'b0;
        total++;
        if (v1 !== 1'b0) begin
            bad++;
            $display("FAIL ack_clear got v=%b want 0", v1);
        end
    endtask

    task automatic test_back_to_back(input int cpb);
        logic [7:0] got [2];
        int n;
        clear_flags();
        got[0] = 8'h00;
        got[1] = 8'h00;
        fork
            begin
                send_frame(cpb, 8'h3C, 1'b1);
                send_frame(cpb, 8'hC3, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_valid(cpb, 30 * cpb, n);
                    got[k] = (cpb == 1) ? data1 : data4;
                    set_ack(cpb, 1'b1);
                    tick();
                    set_ack(cpb, 1'b0);
                end
            end
        join
        total++;
        if (got[0] !== 8'h3C || got[1] !== 8'hC3) begin
            bad++;
            $display("FAIL b2b_cpb%0d got %h %h want 3c c3", cpb, got[0], got[1]);
        end
        repeat (2 * cpb) tick();
        total++;
        if (fe1_n + fe4_n + ov1_n + ov4_n != 0 || ((cpb == 1) ? v1 : v4) !== 1'b0) begin
            bad++;
            $display("FAIL b2b_flags_cpb%0d got fe=%0d ov=%0d want 0 0", cpb, fe1_n + fe4_n, ov1_n + ov4_n);
        end
    endtask

    task automatic test_glitch();
        clear_flags();
        rxd4 = 1'b0;
        tick();
        rxd4 = 1'b1;
        repeat (60) tick();
        total++;
        if (v4 !== 1'b0 || fe4_n != 0 || ov4_n != 0) begin
            bad++;
            $display("FAIL glitch got v=%b fe=%0d ov=%0d want 0 0 0", v4, fe4_n, ov4_n);
        end
    endtask

    task automatic test_break();
        int n;
        clear_flags();
        send_frame(4, 8'h55, 1'b0);
        repeat (20) tick();
        total++;
        if (fe4_n != 1 || v4 !== 1'b0) begin
            bad++;
            $display("FAIL break_fe got fe=%0d v=%b want 1 0", fe4_n, v4);
        end
        rxd4 = 1'b1;
        repeat (8) tick();
        send_frame(4, 8'h12, 1'b1);
        wait_valid(4, 20, n);
        total++;
        if (v4 !== 1'b1 || data4 !== 8'h12 || fe4_n != 1) begin
            bad++;
            $display("FAIL break_recover got v=%b data=%h fe=%0d want 1 12 1", v4, data4, fe4_n);
        end
        ack4 = 1'b1; tick(); ack4 = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        clear_flags();
        send_frame(4, 8'h01, 1'b1);
        wait_valid(4, 20, n);
        send_frame(4, 8'h02, 1'b1);
        repeat (3) tick();
        total++;
        if (ov4_n != 1 || data4 !== 8'h02 || v4 !== 1'b1) begin
            bad++;
            $display("FAIL overrun got ov=%0d data=%h v=%b want 1 02 1", ov4_n, data4, v4);
        end
        ack4 = 1'b1; tick(); ack4 = 1'b0;
        repeat (4) tick();

        clear_flags();
        send_frame(4, 8'h01, 1'b1);
        wait_valid(4, 20, n);
        fork
            send_frame(4, 8'h02, 1'b1);
            begin
                repeat (39) tick();
                ack4 = 1'b1;
                tick();
                ack4 = 1'b0;
            end
        join
        repeat (3) tick();
        total++;
        if (ov4_n != 0 || data4 !== 8'h02 || v4 !== 1'b1) begin
            bad++;
            $display("FAIL ack_same_edge got ov=%0d data=%h v=%b want 0 02 1", ov4_n, data4, v4);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        clear_flags();
        fork
            send_frame(4, 8'hFF, 1'b1);
            begin
                repeat (20) tick();
                rst = 1'b0;
                tick();
                total++;
                if ({data4, v4, fe4, ov4} !== 11'd0) begin
                    bad++;
                    $display("FAIL mid_reset got data=%h v=%b fe=%b ov=%b want all 0", data4, v4, fe4, ov4);
                end
                rst = 1'b1;
            end
        join
        repeat (8) tick();
        total++;
        if (v4 !== 1'b0) begin
            bad++;
            $display("FAIL partial_byte got v=%b want 0", v4);
        end
        send_frame(4, 8'h81, 1'b1);
        wait_valid(4, 20, n);
        total++;
        if (v4 !== 1'b1 || data4 !== 8'h81 || fe4_n != 0 || ov4_n != 0) begin
            bad++;
            $display("FAIL after_reset got v=%b data=%h fe=%0d ov=%0d want 1 81 0 0", v4, data4, fe4_n, ov4_n);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back(1);
        test_back_to_back(4);
        test_glitch();
        test_break();
        test_overrun();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the far end of the team's existing UART transmitter link.
- Frame format: idle-high line, one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
- Recovers each byte from rxd and presents it to the host with a valid/ack handshake.
- Flags framing errors, overruns and a stuck-low (break) line.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit, legal range 1..1024. Default 1 matches the transmitter's one-bit-per-clock timing.
- HALF (localparam), (CLKS_PER_BIT-1)/2, cycle offset at which the start bit is verified.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- rxd  input  1  serial line, asynchronous, idle high.
- rx_ack  input  1  host consumes rx_data when rx_ack=1 while rx_valid=1.
- rx_data  output  8  last good byte, bit0 = first data bit received.
- rx_valid  output  1  high while rx_data holds an unconsumed byte.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  one-cycle pulse when a byte overwrites an unconsumed byte.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, cnt=0, bit_cnt=0, shift=0, sync flops=1, rx_data=0, rx_valid=0, frame_err=0, overrun=0. Reset mid-frame abandons the frame. No partial byte is delivered.
- rxd passes through a 2-flop synchronizer (reset value 1) to give rxd_s. All decisions use rxd_s, which adds 2 cycles of latency.
- cnt is the baud counter, wide enough for CLKS_PER_BIT-1. bit_cnt is 3 bits.
- IDLE, when rxd_s=0:
  - If HALF=0, go to DATA with cnt=0.
  - Otherwise go to START with cnt=1. The detect cycle counts as cycle 0 of the start bit.
- START:
  - If cnt!=HALF, increment cnt.
  - At cnt==HALF with rxd_s=1: false start, return to IDLE with no flags.
  - At cnt==HALF with rxd_s=0: go to DATA with cnt=0 and bit_cnt=0.
- DATA:
  - At cnt==CLKS_PER_BIT-1: shift <= {rxd_s, shift[7:1]}, cnt=0, bit_cnt+1. After the 8th sample (bit_cnt==7) go to STOP.
  - Otherwise increment cnt.
- STOP, at cnt==CLKS_PER_BIT-1:
  - rxd_s=1: rx_data<=shift and rx_valid<=1 on the next edge, then go to IDLE.
  - rxd_s=0: frame_err pulses for 1 cycle, shift is discarded, rx_data and rx_valid are unchanged, then go to BREAK.
- BREAK: stay until rxd_s=1, then go to IDLE. No new frame starts while the line is held low.
- Handshake: an edge with rx_ack=1 and rx_valid=1 clears rx_valid. rx_ack while rx_valid=0 is ignored.
- Simultaneous events:
  - Good stop and ack on the same edge: rx_valid stays 1, rx_data takes the new byte, no overrun.
  - Good stop while rx_valid=1 and no ack: rx_data is overwritten (newest wins), rx_valid stays 1, overrun pulses for 1 cycle.
- Latency: rx_valid rises on the edge after the stop-bit sample. With CLKS_PER_BIT=1 that is 12 cycles after the start bit appears on rxd.
- Back-to-back frames: with a one-cycle stop bit, STOP->IDLE must catch a start bit immediately following. No dead cycle is allowed.
- Illegal state encodings go to IDLE.

Decomposition:
- Shared package uart_pkg:
  - state encodings IDLE/START/DATA/STOP/BREAK;
  - UART_DATA_BITS=8;
  - line levels START_BIT=0 and STOP_BIT=1.
  - The transmitter refactor uses the same package.
- One sub-module: uart_rx_sync, a 2-flop synchronizer with reset value 1. The FSM, counters and output registers stay in uart_receiver.

Test Plan:
- CLKS_PER_BIT=1, transmitter drives 0xA5 -> rx_valid rises 12 cycles after the start bit, rx_data=0xA5, frame_err=0, overrun=0.
- CLKS_PER_BIT=4, frames 0x3C then 0xC3 back-to-back with a 1-bit stop and ack after each -> both bytes received in order, no flags.
- CLKS_PER_BIT=4, one-cycle low glitch on idle rxd -> returns to IDLE from START, rx_valid stays 0, no flags.
- Frame 0x55 with stop bit forced to 0 and line held low 20 cycles -> frame_err pulses once, rx_valid=0, FSM waits in BREAK. Line goes high, then a 0x12 frame -> rx_data=0x12.
- 0x01 unacked, then 0x02 -> overrun pulses once, rx_data=0x02. Repeat with rx_ack on the exact edge 0x02 lands -> no overrun, rx_valid=1.
- rst=0 asserted mid-DATA of 0xFF -> all outputs 0 next edge. A following 0x81 frame is received correctly.
